// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared widths, state encoding and starvation constants for the
// ROM arbiter codebase slice.
//
// Contents:
//   ADDR_W, DATA_W   - byte-address and data widths (32 bits each)
//   STARVE_CNT_W     - width of the fetch starvation counter
//   STARVE_LIMIT     - denied-cycle count after which fetch wins over the loader
//   arb_state_e      - arbiter FSM state encoding (StArb=0, StLocked=1)
package rom_arb_pkg;

   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STARVE_CNT_W = 4;

   localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = 4'd8;

   typedef enum logic {
      StArb    = 1'b0,
      StLocked = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// rom_arb_starve_cnt: counts consecutive cycles in which the fetch port asks
// for the ROM but is not granted. Saturates at STARVE_LIMIT; at_limit_o tells
// the arbiter to give fetch priority on the following cycle.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (clears the counter)
//   if_req_i   - fetch request
//   if_gnt_i   - fetch grant issued by the arbiter this cycle
//   at_limit_o - counter has reached STARVE_LIMIT
module rom_arb_starve_cnt
   import rom_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic if_req_i,
   input  logic if_gnt_i,
   output logic at_limit_o
);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!if_req_i || if_gnt_i) begin
         cnt_d = '0;
      end else if (cnt_q != STARVE_LIMIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == STARVE_LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a single-port ROM between an instruction-fetch port and
// a loader port. Loader has fixed priority; a loader access with ld_lock_i set
// locks the ROM to the loader (busy_o) until the first cycle ld_lock_i drops.
// Reads return registered data one cycle after acceptance; writes give no
// response.
//
// Build option: define ROM_ARB_STARVE_EN to add a starvation counter that
// forces a fetch grant after STARVE_LIMIT consecutive denied cycles, even while
// locked. Without it fetch may be blocked indefinitely.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_req_i, if_addr_i           - fetch read request and byte address
//   if_gnt_o                      - fetch accepted this cycle
//   if_rvalid_o, if_rdata_o       - fetch read response
//   ld_req_i, ld_we_i, ld_addr_i  - loader request, write enable, byte address
//   ld_wdata_i, ld_lock_i         - loader write data, exclusive-burst lock
//   ld_gnt_o                      - loader accepted this cycle
//   ld_rvalid_o, ld_rdata_o       - loader read response
//   rom_we_o, rom_addr_o          - ROM write enable and byte address
//   rom_data_o, rom_data_i        - ROM write data, combinational read data
//   busy_o                        - arbiter is locked to the loader
module rom_arbiter
   import rom_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,

   input  logic              ld_req_i,
   input  logic              ld_we_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_wdata_i,
   input  logic              ld_lock_i,
   output logic              ld_gnt_o,
   output logic              ld_rvalid_o,
   output logic [DATA_W-1:0] ld_rdata_o,

   output logic              rom_we_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic [DATA_W-1:0] rom_data_o,
   input  logic [DATA_W-1:0] rom_data_i,

   output logic              busy_o
);

   arb_state_e        state_q;
   logic              if_rvalid_q;
   logic              ld_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ld_rdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              fetch_first;
   logic              any_gnt;

`ifdef ROM_ARB_STARVE_EN
   rom_arb_starve_cnt u_starve_cnt (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_gnt_i   (if_gnt_o),
      .at_limit_o (fetch_first)
   );
`else
   assign fetch_first = 1'b0;
`endif

   // Grants are combinational from requests and state; reset blocks all grants.
   always_comb begin
      if_gnt_o = 1'b0;
      ld_gnt_o = 1'b0;
      if (!rst) begin
         if (if_req_i && fetch_first) begin
            if_gnt_o = 1'b1;
         end else if (ld_req_i) begin
            ld_gnt_o = 1'b1;
         end else if (if_req_i && (state_q == StArb)) begin
            if_gnt_o = 1'b1;
         end
      end
   end

   assign any_gnt = if_gnt_o | ld_gnt_o;

   // ROM address/data follow the granted requester, otherwise hold last value.
   assign rom_addr_o = ld_gnt_o ? ld_addr_i :
                       if_gnt_o ? if_addr_i : addr_q;
   assign rom_data_o = any_gnt ? ld_wdata_i : wdata_q;
   assign rom_we_o   = ld_gnt_o & ld_we_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StArb;
         if_rvalid_q <= 1'b0;
         ld_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ld_rdata_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            StArb: begin
               if (ld_gnt_o && ld_lock_i) begin
                  state_q <= StLocked;
               end
            end
            StLocked: begin
               if (!ld_lock_i) begin
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase

         if_rvalid_q <= if_gnt_o;
         ld_rvalid_q <= ld_gnt_o & ~ld_we_i;
         if (if_gnt_o) begin
            if_rdata_q <= rom_data_i;
         end
         if (ld_gnt_o && !ld_we_i) begin
            ld_rdata_q <= rom_data_i;
         end
         if (any_gnt) begin
            addr_q  <= rom_addr_o;
            wdata_q <= ld_wdata_i;
         end
      end
   end

   // A response due in a reset cycle is dropped along with the transaction.
   assign if_rvalid_o = if_rvalid_q & ~rst;
   assign ld_rvalid_o = ld_rvalid_q & ~rst;
   assign if_rdata_o  = if_rdata_q;
   assign ld_rdata_o  = ld_rdata_q;
   assign busy_o      = (state_q == StLocked) & ~rst;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model of the arbiter and a
// behavioural ROM.
module tb_rom_arbiter;

`ifdef ROM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif
   localparam int STARVE_CYCLES = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ld_req_i;
   logic        ld_we_i;
   logic [31:0] ld_addr_i;
   logic [31:0] ld_wdata_i;
   logic        ld_lock_i;
   logic        ld_gnt_o;
   logic        ld_rvalid_o;
   logic [31:0] ld_rdata_o;
   logic        rom_we_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_o;
   logic [31:0] rom_data_i;
   logic        busy_o;

   always #5 clk = ~clk;

   rom_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .ld_req_i    (ld_req_i),
      .ld_we_i     (ld_we_i),
      .ld_addr_i   (ld_addr_i),
      .ld_wdata_i  (ld_wdata_i),
      .ld_lock_i   (ld_lock_i),
      .ld_gnt_o    (ld_gnt_o),
      .ld_rvalid_o (ld_rvalid_o),
      .ld_rdata_o  (ld_rdata_o),
      .rom_we_o    (rom_we_o),
      .rom_addr_o  (rom_addr_o),
      .rom_data_o  (rom_data_o),
      .rom_data_i  (rom_data_i),
      .busy_o      (busy_o)
   );

   // Behavioural ROM driven by the DUT's ROM port (64 words).
   logic [31:0] rom_mem [64];
   assign rom_data_i = rom_mem[rom_addr_o[7:2]];

   // Reference model state.
   logic [31:0] ref_mem [64];
   bit          m_locked;
   int          m_starve;
   bit          m_if_rv, m_ld_rv;
   logic [31:0] m_if_rd, m_ld_rd;
   logic [31:0] m_addr_hold, m_data_hold;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          last_if_gnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare DUT outputs with the model, then
   // advance the model across the clock edge.
   task automatic step(input bit r, input bit ifr, input logic [31:0] ifa, input bit ldr,
                       input bit we, input logic [31:0] lda, input logic [31:0] wd,
                       input bit lk);
      bit          eg_if, eg_ld;
      logic [31:0] e_addr, e_data;
      bit          w_en;
      logic [5:0]  w_idx;
      logic [31:0] w_dat;

      rst = r; if_req_i = ifr; if_addr_i = ifa; ld_req_i = ldr; ld_we_i = we;
      ld_addr_i = lda; ld_wdata_i = wd; ld_lock_i = lk;
      #3;

      eg_if = 1'b0;
      eg_ld = 1'b0;
      if (!r) begin
         if (ifr && STARVE && m_starve >= STARVE_CYCLES) eg_if = 1'b1;
         else if (ldr) eg_ld = 1'b1;
         else if (ifr && !m_locked) eg_if = 1'b1;
      end
      e_addr = eg_ld ? lda : (eg_if ? ifa : m_addr_hold);
      e_data = (eg_if || eg_ld) ? wd : m_data_hold;

      check("if_gnt", 32'(if_gnt_o), 32'(eg_if));
      check("ld_gnt", 32'(ld_gnt_o), 32'(eg_ld));
      check("busy", 32'(busy_o), 32'(m_locked && !r));
      check("rom_we", 32'(rom_we_o), 32'(eg_ld && we));
      check("rom_addr", rom_addr_o, e_addr);
      check("rom_data", rom_data_o, e_data);
      check("if_rvalid", 32'(if_rvalid_o), 32'(m_if_rv && !r));
      check("ld_rvalid", 32'(ld_rvalid_o), 32'(m_ld_rv && !r));
      check("if_rdata", if_rdata_o, m_if_rd);
      check("ld_rdata", ld_rdata_o, m_ld_rd);
      last_if_gnt = if_gnt_o;

      w_en  = rom_we_o;
      w_idx = rom_addr_o[7:2];
      w_dat = rom_data_o;

      if (r) begin
         m_locked = 0; m_starve = 0; m_if_rv = 0; m_ld_rv = 0;
         m_if_rd = '0; m_ld_rd = '0; m_addr_hold = '0; m_data_hold = '0;
      end else begin
         m_if_rv = eg_if;
         m_ld_rv = eg_ld && !we;
         if (eg_if) m_if_rd = ref_mem[ifa[7:2]];
         if (eg_ld && !we) m_ld_rd = ref_mem[lda[7:2]];
         if (eg_ld && we) ref_mem[lda[7:2]] = wd;
         if (eg_if || eg_ld) begin
            m_addr_hold = e_addr;
            m_data_hold = wd;
         end
         m_locked = m_locked ? lk : (eg_ld && lk);
         if (!ifr || eg_if) m_starve = 0;
         else if (m_starve < STARVE_CYCLES) m_starve++;
      end

      @(posedge clk);
      #1;
      if (w_en) rom_mem[w_idx] = w_dat;
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
   endtask

   initial begin
      logic [31:0] first_gnt;
      logic [31:0] exp_first;

      for (int i = 0; i < 64; i++) begin
         rom_mem[i] = 32'h1000_0000 ^ (i * 32'h0101_0103);
         ref_mem[i] = 32'h1000_0000 ^ (i * 32'h0101_0103);
      end
      rst = 1; if_req_i = 0; if_addr_i = '0; ld_req_i = 0; ld_we_i = 0;
      ld_addr_i = '0; ld_wdata_i = '0; ld_lock_i = 0;
      repeat (2) @(posedge clk);
      #1;
      m_locked = 0; m_starve = 0; m_if_rv = 0; m_ld_rv = 0;
      m_if_rd = '0; m_ld_rd = '0; m_addr_hold = '0; m_data_hold = '0;

      // Reset state, then release.
      step(1, 1, 32'h4, 1, 1, 32'h8, 32'h1234, 1);
      idle();

      // Simultaneous requests: loader wins, fetch follows.
      step(0, 1, 32'h10, 1, 0, 32'h20, 32'h0, 0);
      step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0);
      idle();

      // Locked write burst with fetch pending, then read back.
      for (int c = 0; c < 4; c++) step(0, 1, 32'h8, 1, 1, 32'h40, 32'hDEAD_BEEF, 1);
      step(0, 1, 32'h8, 1, 0, 32'h40, 32'h0, 0);
      idle();
      check("burst_readback", ld_rdata_o, 32'hDEAD_BEEF);
      idle();

      // Fetch stream with byte-offset passthrough on the last access.
      for (int c = 0; c < 5; c++) step(0, 1, 32'(c * 4), 0, 0, 32'h0, 32'h0, 0);
      step(0, 1, 32'h0000_0107, 0, 0, 32'h0, 32'h0, 0);
      idle();

      // Reset one cycle after a read accept drops the response.
      step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
      step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      idle();

      // Starvation under a continuous locked loader.
      first_gnt = 32'd99;
      for (int c = 0; c < 12; c++) begin
         step(0, 1, 32'h24, 1, 0, 32'h30, 32'h0, 1);
         if (last_if_gnt && first_gnt == 32'd99) first_gnt = 32'(c);
      end
      exp_first = STARVE ? 32'(STARVE_CYCLES) : 32'd99;
      check("starve_first_gnt", first_gnt, exp_first);
      idle();
      idle();

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         logic [31:0] ia, la;
         ia = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
         la = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), ia,
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 2) == 0), la, $urandom,
              ($urandom_range(0, 9) < 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
- REQ-001 SHALL run on one clock with synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
- REQ-002 SHALL provide these fetch ports: if_req_i input 1 fetch read request; if_addr_i input 32 byte address; if_gnt_o output 1 request accepted this cycle; if_rvalid_o output 1 read data valid; if_rdata_o output 32 read data.
- REQ-003 SHALL provide these loader ports: ld_req_i input 1 loader request; ld_we_i input 1 write (1) or read (0); ld_addr_i input 32 byte address; ld_wdata_i input 32 write data; ld_lock_i input 1 exclusive-burst lock; ld_gnt_o output 1 accepted; ld_rvalid_o output 1 read data valid; ld_rdata_o output 32 read data.
- REQ-004 SHALL provide these ROM ports: rom_we_o output 1 write enable; rom_addr_o output 32 byte address; rom_data_o output 32 write data; rom_data_i input 32 combinational read data.
- REQ-005 SHALL provide busy_o output 1, asserted while state is LOCKED.

Function
- REQ-006 SHALL accept at most one access per cycle. Acceptance is req && gnt in the same cycle. gnt is combinational from req and state.
- REQ-007 SHALL have FSM states ARB and LOCKED.
  - ARB -> LOCKED: on loader acceptance with ld_lock_i=1.
  - LOCKED -> ARB: first cycle ld_lock_i=0.
- REQ-008 SHALL use fixed priority in ARB: loader over fetch. In LOCKED, only the loader is granted; fetch gnt=0 (except REQ-016).
- REQ-009 SHALL drive ROM outputs from the granted requester in the accept cycle:
  - rom_addr_o = granted address.
  - rom_we_o = ld_we_i only when the loader is granted, else 0.
  - rom_data_o = ld_wdata_i.
  - With no grant: rom_we_o=0, and rom_addr_o and rom_data_o hold their last value.
- REQ-010 SHALL register rom_data_i at the end of an accepted read. The matching rvalid is high for exactly one cycle, one cycle after acceptance (latency 1). rdata holds its value until the next read response.
- REQ-011 SHALL produce no rvalid for accepted writes.
- REQ-012 SHALL pass address bits [1:0] through unchanged; word selection is the ROM's responsibility.
- REQ-013 SHALL let the loader be granted back-to-back every cycle. Reads and writes to the same address in consecutive cycles SHALL return the new data (write-then-read ordering preserved).
- REQ-014 SHALL ignore ld_lock_i while ld_req_i=0 in ARB.

Reset
- REQ-015 SHALL reset all of the following on rst=1 at a clock edge, with rst taking precedence over any request that cycle:
  - state = ARB;
  - if_rvalid_o, ld_rvalid_o, if_rdata_o, ld_rdata_o = 0;
  - rom_addr_o, rom_data_o = 0;
  - starvation counter = 0.
  - During rst=1, rom_we_o, if_gnt_o, ld_gnt_o and busy_o SHALL be 0.
  - A read accepted in the cycle before reset SHALL produce no rvalid.

Configuration
- REQ-016 SHALL compile in an anti-starvation feature when ROM_ARB_STARVE_EN is defined:
  - A 4-bit counter increments each cycle where if_req_i=1 and if_gnt_o=0, saturating at STARVE_LIMIT (8).
  - At the limit, the next cycle grants fetch over the loader, in ARB or LOCKED. The lock state itself is unchanged.
  - The counter clears on any fetch grant or when if_req_i=0.
- REQ-017 SHALL, without ROM_ARB_STARVE_EN, omit the counter entirely; fetch can be blocked indefinitely.

Structure
- REQ-018 SHALL place STARVE_LIMIT, the counter width, the state encoding (ARB=0, LOCKED=1) and the 32-bit data and address widths in shared package rom_arb_pkg.
- REQ-019 SHALL implement the starvation counter as sub-module rom_arb_starve_cnt, instantiated only under ROM_ARB_STARVE_EN.

Verification
- REQ-020 Simultaneous requests: if_req_i=1 @0x10, ld_req_i=1 read @0x20 in the same cycle -> ld_gnt_o=1, if_gnt_o=0, ld_rvalid_o next cycle with ROM[0x20]; fetch granted the following cycle.
- REQ-021 Locked burst: loader write 0xDEADBEEF @0x40 with ld_lock_i=1 for 4 cycles while fetch requests -> busy_o=1, no fetch grants during the burst, then loader read @0x40 returns 0xDEADBEEF.
- REQ-022 Fetch stream: if_req_i held 5 cycles at 0x0,0x4,...,0x10 -> five gnts, five rvalids each lagging its gnt by one cycle, correct data.
- REQ-023 Mid-burst reset: rst pulsed one cycle after a read accept -> no rvalid, state ARB, all outputs 0.
- REQ-024 Starvation (ROM_ARB_STARVE_EN): loader locked with continuous requests, fetch requesting -> fetch granted after exactly 8 denied cycles; without the macro -> never granted.
